// File: rtl/dmem_arbiter_if.sv
// Bundle of the core load/store port, the host burst port and the data_mem port
// around the data memory arbiter.
interface dmem_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8,
    parameter int LW = 4
);
    logic          core_req;
    logic          core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic          core_stall;
    logic [DW-1:0] core_rdata;
    logic          core_rvalid;

    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [LW-1:0] host_len;
    logic          host_gnt;
    logic [DW-1:0] host_wdata;
    logic          host_wvalid;
    logic          host_wready;
    logic [DW-1:0] host_rdata;
    logic          host_rvalid;
    logic          host_busy;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rd;
    logic          mem_wr;
    logic [DW-1:0] mem_rdata;

    // Arbiter side
    modport master (
        input  core_req, core_we, core_addr, core_wdata,
        output core_stall, core_rdata, core_rvalid,
        input  host_req, host_we, host_addr, host_len, host_wdata, host_wvalid,
        output host_gnt, host_wready, host_rdata, host_rvalid, host_busy,
        output mem_addr, mem_wdata, mem_rd, mem_wr,
        input  mem_rdata
    );

    // Requester / memory side
    modport slave (
        output core_req, core_we, core_addr, core_wdata,
        input  core_stall, core_rdata, core_rvalid,
        output host_req, host_we, host_addr, host_len, host_wdata, host_wvalid,
        input  host_gnt, host_wready, host_rdata, host_rvalid, host_busy,
        input  mem_addr, mem_wdata, mem_rd, mem_wr,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: core single-beat accesses with priority,
// host bursts of 1..16 beats with a starvation guard forcing a host grant.
module dmem_arbiter #(
    parameter int AW           = 8,
    parameter int DW           = 8,
    parameter int LW           = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic           CLK,
    input  logic           RST_N,
    dmem_arbiter_if.master bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, BURST_RD, BURST_WR} state_t;

    state_t        state_reg, state_next;
    logic [SW-1:0] starve_reg, starve_next;
    logic [LW-1:0] beat_idx_reg, beat_idx_next;
    logic [LW-1:0] len_reg, len_next;
    logic [AW-1:0] base_reg, base_next;
    logic [DW-1:0] core_rdata_reg, host_rdata_reg;
    logic          core_rvalid_reg, host_rvalid_reg;
    logic          core_load, host_rd_beat;
    logic [AW-1:0] burst_addr;

    assign burst_addr = base_reg + AW'(beat_idx_reg);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg       <= IDLE;
            starve_reg      <= '0;
            beat_idx_reg    <= '0;
            len_reg         <= '0;
            base_reg        <= '0;
            core_rdata_reg  <= '0;
            host_rdata_reg  <= '0;
            core_rvalid_reg <= 1'b0;
            host_rvalid_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            starve_reg      <= starve_next;
            beat_idx_reg    <= beat_idx_next;
            len_reg         <= len_next;
            base_reg        <= base_next;
            core_rvalid_reg <= core_load;
            host_rvalid_reg <= host_rd_beat;
            if (core_load)
                core_rdata_reg <= bus.mem_rdata;
            if (host_rd_beat)
                host_rdata_reg <= bus.mem_rdata;
        end
    end

    always_comb begin
        state_next      = state_reg;
        starve_next     = starve_reg;
        beat_idx_next   = beat_idx_reg;
        len_next        = len_reg;
        base_next       = base_reg;
        core_load       = 1'b0;
        host_rd_beat    = 1'b0;
        bus.core_stall  = bus.core_req;
        bus.host_gnt    = 1'b0;
        bus.host_wready = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;
        bus.mem_rd      = 1'b0;
        bus.mem_wr      = 1'b0;

        case (state_reg)
            IDLE: begin
                // RST_N gates the combinational paths so nothing reaches memory while in reset
                if (RST_N) begin
                    if (bus.host_req && (!bus.core_req || starve_reg == SW'(STARVE_LIMIT))) begin
                        bus.host_gnt  = 1'b1;
                        base_next     = bus.host_addr;
                        len_next      = bus.host_len;
                        beat_idx_next = '0;
                        starve_next   = '0;
                        state_next    = bus.host_we ? BURST_WR : BURST_RD;
                    end else begin
                        if (!bus.host_req)
                            starve_next = '0;
                        else if (starve_reg != SW'(STARVE_LIMIT))
                            starve_next = starve_reg + SW'(1);
                        if (bus.core_req) begin
                            bus.core_stall = 1'b0;
                            bus.mem_addr   = bus.core_addr;
                            bus.mem_wdata  = bus.core_wdata;
                            bus.mem_rd     = !bus.core_we;
                            bus.mem_wr     = bus.core_we;
                            core_load      = !bus.core_we;
                        end
                    end
                end
            end
            BURST_RD: begin
                bus.mem_rd   = 1'b1;
                bus.mem_addr = burst_addr;
                host_rd_beat = 1'b1;
                if (beat_idx_reg == len_reg)
                    state_next = IDLE;
                else
                    beat_idx_next = beat_idx_reg + LW'(1);
            end
            BURST_WR: begin
                bus.host_wready = 1'b1;
                bus.mem_wr      = bus.host_wvalid;
                bus.mem_addr    = burst_addr;
                bus.mem_wdata   = bus.host_wdata;
                // Write bubbles simply hold the beat index
                if (bus.host_wvalid) begin
                    if (beat_idx_reg == len_reg)
                        state_next = IDLE;
                    else
                        beat_idx_next = beat_idx_reg + LW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.core_rdata  = core_rdata_reg;
    assign bus.core_rvalid = core_rvalid_reg;
    assign bus.host_rdata  = host_rdata_reg;
    assign bus.host_rvalid = host_rvalid_reg;
    assign bus.host_busy   = (state_reg != IDLE);
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scenario bench for dmem_arbiter with a behavioural data_mem and read-data scoreboards.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(8), .DW(8), .LW(4)) bus ();

    dmem_arbiter #(.AW(8), .DW(8), .LW(4), .STARVE_LIMIT(8)) dut (
        .CLK  (clk),
        .RST_N(rst_n),
        .bus  (bus)
    );

    logic [7:0] ram     [256];
    logic [7:0] ref_mem [256];
    logic [7:0] core_q  [$];
    logic [7:0] host_q  [$];
    int compared   = 0;
    int mismatched = 0;

    assign bus.mem_rdata = ram[bus.mem_addr];
    always @(posedge clk)
        if (bus.mem_wr) ram[bus.mem_addr] <= bus.mem_wdata;

    // Read-data monitor: pops the expected value whenever a read beat returns
    always @(negedge clk) begin
        logic [7:0] exp_v;
        if (rst_n) begin
            compared++;
            if (bus.mem_rd && bus.mem_wr) begin
                mismatched++;
                $display("FAIL rd_wr_excl: mem_rd=%b mem_wr=%b required not both 1", bus.mem_rd, bus.mem_wr);
            end
            if (bus.core_rvalid) begin
                compared++;
                if (core_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL core_rvalid_unexpected: got data %h, required no pulse", bus.core_rdata);
                end else begin
                    exp_v = core_q.pop_front();
                    if (bus.core_rdata !== exp_v) begin
                        mismatched++;
                        $display("FAIL core_rdata: got %h required %h", bus.core_rdata, exp_v);
                    end else
                        $display("core load data %h ok", bus.core_rdata);
                end
            end
            if (bus.host_rvalid) begin
                compared++;
                if (host_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL host_rvalid_unexpected: got data %h, required no pulse", bus.host_rdata);
                end else begin
                    exp_v = host_q.pop_front();
                    if (bus.host_rdata !== exp_v) begin
                        mismatched++;
                        $display("FAIL host_rdata: got %h required %h", bus.host_rdata, exp_v);
                    end else
                        $display("host read beat %h ok", bus.host_rdata);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.core_req = 1'b1;
        @(negedge clk);
        compared += 6;
        if (bus.core_stall !== 1'b1) begin mismatched++; $display("FAIL reset_stall: got %b required 1", bus.core_stall); end
        if (bus.mem_rd !== 1'b0 || bus.mem_wr !== 1'b0) begin mismatched++; $display("FAIL reset_mem: rd=%b wr=%b required 0", bus.mem_rd, bus.mem_wr); end
        if (bus.mem_addr !== 8'h00 || bus.mem_wdata !== 8'h00) begin mismatched++; $display("FAIL reset_mem_bus: addr=%h wdata=%h required 00", bus.mem_addr, bus.mem_wdata); end
        if (bus.host_gnt !== 1'b0 || bus.host_busy !== 1'b0) begin mismatched++; $display("FAIL reset_host: gnt=%b busy=%b required 0", bus.host_gnt, bus.host_busy); end
        if (bus.core_rvalid !== 1'b0 || bus.host_rvalid !== 1'b0) begin mismatched++; $display("FAIL reset_rvalid: core=%b host=%b required 0", bus.core_rvalid, bus.host_rvalid); end
        if (bus.core_rdata !== 8'h00 || bus.host_rdata !== 8'h00) begin mismatched++; $display("FAIL reset_rdata: core=%h host=%h required 00", bus.core_rdata, bus.host_rdata); end
        $display("reset state checked");
        next_cycle();
        rst_n = 1'b1;
        bus.core_req = 1'b0;
    endtask

    task automatic test_core_rw();
        next_cycle();
        bus.core_req = 1'b1; bus.core_we = 1'b1; bus.core_addr = 8'h10; bus.core_wdata = 8'hA5;
        @(negedge clk);
        compared += 2;
        if (bus.core_stall !== 1'b0) begin mismatched++; $display("FAIL core_store_stall: got %b required 0", bus.core_stall); end
        if (bus.mem_wr !== 1'b1 || bus.mem_addr !== 8'h10 || bus.mem_wdata !== 8'hA5) begin
            mismatched++; $display("FAIL core_store_bus: wr=%b addr=%h wdata=%h required 1 10 a5", bus.mem_wr, bus.mem_addr, bus.mem_wdata);
        end
        ref_mem[8'h10] = 8'hA5;
        $display("core store 10 <= a5");
        next_cycle();
        bus.core_we = 1'b0;
        @(negedge clk);
        compared += 2;
        if (bus.core_stall !== 1'b0) begin mismatched++; $display("FAIL core_load_stall: got %b required 0", bus.core_stall); end
        if (bus.mem_rd !== 1'b1 || bus.mem_wr !== 1'b0 || bus.mem_addr !== 8'h10) begin
            mismatched++; $display("FAIL core_load_bus: rd=%b wr=%b addr=%h required 1 0 10", bus.mem_rd, bus.mem_wr, bus.mem_addr);
        end
        core_q.push_back(ref_mem[8'h10]);
        next_cycle();
        bus.core_req = 1'b0;
        @(negedge clk);
        compared++;
        if (bus.core_rvalid !== 1'b1) begin mismatched++; $display("FAIL core_rvalid_latency: got %b required 1", bus.core_rvalid); end
        next_cycle();
    endtask

    task automatic test_host_read();
        logic [7:0] a;
        bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 8'hFE; bus.host_len = 4'd3;
        @(negedge clk);
        compared++;
        if (bus.host_gnt !== 1'b1 || bus.mem_rd !== 1'b0 || bus.host_busy !== 1'b0) begin
            mismatched++; $display("FAIL hrd_grant: gnt=%b rd=%b busy=%b required 1 0 0", bus.host_gnt, bus.mem_rd, bus.host_busy);
        end
        next_cycle();
        bus.host_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = 8'hFE + 8'(i);
            @(negedge clk);
            compared++;
            if (bus.mem_rd !== 1'b1 || bus.mem_addr !== a || bus.host_busy !== 1'b1) begin
                mismatched++; $display("FAIL hrd_beat%0d: rd=%b addr=%h busy=%b required 1 %h 1", i, bus.mem_rd, bus.mem_addr, bus.host_busy, a);
            end
            host_q.push_back(ref_mem[a]);
            $display("host read beat %0d addr %h issued", i, a);
            next_cycle();
        end
        @(negedge clk);
        compared++;
        if (bus.host_busy !== 1'b0 || bus.mem_rd !== 1'b0) begin
            mismatched++; $display("FAIL hrd_end: busy=%b rd=%b required 0 0", bus.host_busy, bus.mem_rd);
        end
        next_cycle();
    endtask

    task automatic test_starvation();
        bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 8'h20;
        bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 8'h40; bus.host_len = 4'd1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            compared++;
            if (bus.host_gnt !== 1'b0 || bus.core_stall !== 1'b0 || bus.mem_addr !== 8'h20) begin
                mismatched++; $display("FAIL starve_deny%0d: gnt=%b stall=%b addr=%h required 0 0 20", c, bus.host_gnt, bus.core_stall, bus.mem_addr);
            end
            core_q.push_back(ref_mem[8'h20]);
            $display("denied host cycle %0d, core served", c);
            next_cycle();
        end
        @(negedge clk);
        compared++;
        if (bus.host_gnt !== 1'b1 || bus.core_stall !== 1'b1 || bus.mem_rd !== 1'b0) begin
            mismatched++; $display("FAIL starve_grant: gnt=%b stall=%b rd=%b required 1 1 0", bus.host_gnt, bus.core_stall, bus.mem_rd);
        end
        next_cycle();
        bus.host_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            compared++;
            if (bus.core_stall !== 1'b1 || bus.mem_rd !== 1'b1 || bus.mem_addr !== 8'h40 + 8'(i)) begin
                mismatched++; $display("FAIL starve_burst%0d: stall=%b rd=%b addr=%h required 1 1 %h", i, bus.core_stall, bus.mem_rd, bus.mem_addr, 8'h40 + 8'(i));
            end
            host_q.push_back(ref_mem[8'h40 + 8'(i)]);
            next_cycle();
        end
        @(negedge clk);
        compared++;
        if (bus.core_stall !== 1'b0 || bus.mem_addr !== 8'h20 || bus.mem_rd !== 1'b1) begin
            mismatched++; $display("FAIL starve_core_resume: stall=%b addr=%h rd=%b required 0 20 1", bus.core_stall, bus.mem_addr, bus.mem_rd);
        end
        core_q.push_back(ref_mem[8'h20]);
        $display("core resumed after forced burst");
        next_cycle();
        bus.core_req = 1'b0;
    endtask

    task automatic test_host_write();
        logic pat [4];
        logic [7:0] b;
        pat = '{1'b1, 1'b0, 1'b1, 1'b1};
        b = 8'h00;
        bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 8'h80; bus.host_len = 4'd2;
        @(negedge clk);
        compared++;
        if (bus.host_gnt !== 1'b1 || bus.mem_wr !== 1'b0) begin
            mismatched++; $display("FAIL hwr_grant: gnt=%b wr=%b required 1 0", bus.host_gnt, bus.mem_wr);
        end
        next_cycle();
        bus.host_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.host_wvalid = pat[k];
            bus.host_wdata  = 8'hC0 + 8'(k);
            @(negedge clk);
            compared++;
            if (bus.host_wready !== 1'b1 || bus.mem_wr !== pat[k]) begin
                mismatched++; $display("FAIL hwr_cycle%0d: wready=%b wr=%b required 1 %b", k, bus.host_wready, bus.mem_wr, pat[k]);
            end
            if (pat[k]) begin
                compared++;
                if (bus.mem_addr !== 8'h80 + b || bus.mem_wdata !== 8'hC0 + 8'(k)) begin
                    mismatched++; $display("FAIL hwr_beat%0d: addr=%h data=%h required %h %h", b, bus.mem_addr, bus.mem_wdata, 8'h80 + b, 8'hC0 + 8'(k));
                end
                ref_mem[8'h80 + b] = 8'hC0 + 8'(k);
                $display("host write beat %0d addr %h", b, 8'h80 + b);
                b++;
            end
            next_cycle();
        end
        bus.host_wvalid = 1'b0;
        @(negedge clk);
        compared++;
        if (bus.host_busy !== 1'b0 || bus.host_wready !== 1'b0) begin
            mismatched++; $display("FAIL hwr_end: busy=%b wready=%b required 0 0", bus.host_busy, bus.host_wready);
        end
        // Read back the burst through the core port; 0x83 must be untouched
        bus.core_req = 1'b1; bus.core_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.core_addr = 8'h80 + 8'(i);
            core_q.push_back(ref_mem[8'h80 + 8'(i)]);
            next_cycle();
        end
        bus.core_req = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset_mid_burst();
        bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 8'h90; bus.host_len = 4'd3;
        next_cycle();
        bus.host_req = 1'b0; bus.host_wvalid = 1'b1; bus.host_wdata = 8'h77;
        ref_mem[8'h90] = 8'h77;
        next_cycle();
        rst_n = 1'b0;
        #1;
        compared += 2;
        if (bus.host_busy !== 1'b0 || bus.host_wready !== 1'b0 || bus.mem_wr !== 1'b0) begin
            mismatched++; $display("FAIL rst_mid_burst: busy=%b wready=%b wr=%b required 0 0 0", bus.host_busy, bus.host_wready, bus.mem_wr);
        end
        if (bus.mem_addr !== 8'h00 || bus.host_rvalid !== 1'b0 || bus.core_rvalid !== 1'b0) begin
            mismatched++; $display("FAIL rst_mid_outputs: addr=%h hrv=%b crv=%b required 00 0 0", bus.mem_addr, bus.host_rvalid, bus.core_rvalid);
        end
        $display("reset asserted mid write burst");
        next_cycle();
        rst_n = 1'b1; bus.host_wvalid = 1'b0;
        next_cycle();
        bus.core_req = 1'b1; bus.core_we = 1'b1; bus.core_addr = 8'h30; bus.core_wdata = 8'h3C;
        @(negedge clk);
        compared++;
        if (bus.core_stall !== 1'b0 || bus.mem_wr !== 1'b1 || bus.mem_addr !== 8'h30) begin
            mismatched++; $display("FAIL post_reset_core: stall=%b wr=%b addr=%h required 0 1 30", bus.core_stall, bus.mem_wr, bus.mem_addr);
        end
        ref_mem[8'h30] = 8'h3C;
        $display("core store after reset");
        next_cycle();
        bus.core_we = 1'b0;
        core_q.push_back(ref_mem[8'h30]);
        next_cycle();
        bus.core_req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]     = 8'(i) ^ 8'h5A;
            ref_mem[i] = 8'(i) ^ 8'h5A;
        end
        bus.core_req = 1'b0; bus.core_we = 1'b0; bus.core_addr = '0; bus.core_wdata = '0;
        bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_len = '0;
        bus.host_wdata = '0; bus.host_wvalid = 1'b0;

        test_reset();
        test_core_rw();
        test_host_read();
        test_starvation();
        test_host_write();
        test_reset_mid_burst();

        for (int i = 0; i < 10 && (core_q.size() != 0 || host_q.size() != 0); i++)
            next_cycle();
        compared++;
        if (core_q.size() != 0 || host_q.size() != 0) begin
            mismatched++; $display("FAIL rvalid_missing: core pending=%0d host pending=%0d required 0 0", core_q.size(), host_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the core load/store path and a host port used for program-data initialisation and result dump.
- Core accesses are single-beat. Host accesses are bursts of 1..16 beats with auto-incrementing addresses.
- Core has priority. A starvation counter forces a host grant after STARVE_LIMIT denied cycles.
- Sits between the core's memory control path and data_mem. Drives core stall.

Parameters:
- AW, 8, address width
- DW, 8, data width
- LW, 4, host burst length field width (beats = host_len+1)
- STARVE_LIMIT, 8, denied host cycles before forced host grant

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- core_req  in  1  core access request, held until not stalled
- core_we  in  1  1=store, 0=load
- core_addr  in  AW  core address
- core_wdata  in  DW  core store data
- core_stall  out  1  core request not served this cycle
- core_rdata  out  DW  registered load data
- core_rvalid  out  1  one-cycle pulse, load data valid
- host_req  in  1  burst request, held until host_gnt
- host_we  in  1  1=write burst
- host_addr  in  AW  burst base address
- host_len  in  LW  beats minus one
- host_gnt  out  1  one-cycle pulse, burst accepted
- host_wdata  in  DW  write beat data
- host_wvalid  in  1  write beat offered
- host_wready  out  1  write beat accepted this cycle
- host_rdata  out  DW  registered read beat data
- host_rvalid  out  1  read beat valid pulse
- host_busy  out  1  burst in progress
- mem_addr  out  AW  to data_mem DataAddress
- mem_wdata  out  DW  to data_mem DataIn
- mem_rd  out  1  to data_mem ReadMem
- mem_wr  out  1  to data_mem WriteMem
- mem_rdata  in  DW  from data_mem DataOut, combinational in same cycle as mem_rd

Behaviour:
- Reset (async, RST_N=0):
  - State=IDLE; starve_cnt=0; beat_idx=0.
  - All outputs 0: core_rvalid, host_rvalid, host_gnt, host_busy, mem_rd, mem_wr, mem_addr, mem_wdata, both rdata.
  - core_stall is combinational and equals core_req while in reset.
  - Reset mid-burst abandons the burst. No pending rvalid survives.
- States: IDLE, BURST_RD, BURST_WR.
- IDLE arbitration, evaluated every cycle:
  - Host grant condition: host_req && (!core_req || starve_cnt==STARVE_LIMIT).
  - On host grant: host_gnt=1 this cycle. Latch host_addr/host_len/host_we at the clock edge. beat_idx<=0. Next state BURST_WR if we, else BURST_RD. No memory access this cycle. core_stall=core_req.
  - Else if core_req: issue this cycle.
    - mem_addr=core_addr; mem_rd=!core_we; mem_wr=core_we; mem_wdata=core_wdata; core_stall=0.
    - On a load: core_rdata<=mem_rdata and core_rvalid=1 the following cycle.
  - Else: no access. mem_rd=mem_wr=0.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) when in IDLE with host_req && core_req and no host grant.
  - Clears on host_gnt or when host_req=0.
  - Holds during a burst.
- BURST_RD:
  - Every cycle issue mem_rd at base+beat_idx, modulo 2^AW (wraps 0xFF->0x00).
  - host_rdata<=mem_rdata; host_rvalid pulses the next cycle.
  - Each beat takes exactly 1 cycle.
- BURST_WR:
  - host_wready=1. mem_wr=host_wvalid; mem_addr=base+beat_idx; mem_wdata=host_wdata.
  - beat_idx advances only on host_wvalid. Bubbles are allowed.
- Burst completion:
  - On the beat where beat_idx==len, return to IDLE next cycle.
  - A core request waiting during that last beat is served in the first IDLE cycle.
- During bursts:
  - host_busy=1 in BURST_* states.
  - core_stall=core_req throughout.
  - host_req is ignored; a new burst needs a fresh arbitration in IDLE.
- mem_rd and mem_wr are never both 1.
- Exactly one requester drives the memory in any cycle.
- Latency: core load issue to core_rvalid is 1 cycle. Host grant to first read beat is 1 cycle; to first rvalid is 2 cycles.

Test Plan:
- Reset, then core store addr=0x10 data=0xA5; next cycle load 0x10 -> core_stall=0 both cycles; core_rvalid one cycle after load with core_rdata=0xA5.
- Idle core, host read burst addr=0xFE len=3 -> host_gnt at cycle 0; mem_addr sequence 0xFE,0xFF,0x00,0x01 in cycles 1-4; four host_rvalid pulses in cycles 2-5; host_busy low at cycle 5.
- Core_req held continuously with host_req=1 -> host denied 8 cycles while starve_cnt counts 0..8; host_gnt in the 9th cycle; core_stall=1 from that cycle through the last burst beat; core served the cycle after.
- Host write burst len=2 with host_wvalid pattern 1,0,1,1 -> exactly three mem_wr pulses at base, base+1, base+2; burst ends after the 4th cycle.
- Assert RST_N=0 mid-write burst after beat 1 -> outputs zero immediately, state IDLE; after release, core access served with no stall.
- Same-cycle core_req and host_req with starve_cnt<8 -> core served, host_gnt=0, starve_cnt increments by 1.
